// File: rtl/face_swap_pkg.sv
// face_swap_pkg: shared FSM state type and default widths for the face-swap stream controller.
package face_swap_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DIM_W_DEF  = 11;
  localparam int ERR_CNT_W  = 16;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DONE} state_e;
endpackage

// File: rtl/face_swap_axis_reg.sv
// face_swap_axis_reg: one-stage valid/ready register slice carrying data plus sideband bits.
module face_swap_axis_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] data_q;
  logic         valid_q;
  assign in_ready  = !valid_q || out_ready;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end
endmodule

// File: rtl/face_swap_ctrl.sv
// face_swap_ctrl: frame-aligned AXI-Stream pass-through that regenerates tlast/tuser and flags ROI pixels.
// Defining FACE_SWAP_ERR_CNT_EN adds a saturating err_cnt output counting error events.
module face_swap_ctrl
  import face_swap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cfg_start,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [DIM_W-1:0]  roi_x0,
  input  logic [DIM_W-1:0]  roi_y0,
  input  logic [DIM_W-1:0]  roi_w,
  input  logic [DIM_W-1:0]  roi_h,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              m_roi,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef FACE_SWAP_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);
  state_e state_q, state_d;
  logic [DIM_W-1:0] w_q, h_q, rx_q, ry_q, rw_q, rh_q;
  logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
  logic [DIM_W:0] rx_end, ry_end;
  logic err_q, err_d, done_q, done_d;
  logic slice_rdy, in_stream, acc, fwd, start_ok, start_bad;
  logic last_x, last_px, err_ev, in_roi, drained;
  logic [DATA_W+2:0] pl_in, pl_out;
  assign in_stream     = state_q == WAIT_SOF || state_q == ACTIVE;
  assign s_axis_tready = in_stream && slice_rdy;
  assign acc           = s_axis_tvalid && s_axis_tready;
  // Before SOF only a tuser beat is forwarded; everything else is dropped.
  assign fwd           = acc && (state_q == ACTIVE || s_axis_tuser);
  assign start_ok      = cfg_start && state_q == IDLE && cfg_width != '0 && cfg_height != '0;
  assign start_bad     = cfg_start && state_q == IDLE && (cfg_width == '0 || cfg_height == '0);
  assign last_x        = x_q == w_q - DIM_W'(1);
  assign last_px       = last_x && y_q == h_q - DIM_W'(1);
  assign err_ev        = start_bad ||
                         (fwd && (s_axis_tlast != last_x || (state_q == ACTIVE && s_axis_tuser)));
  // Extra bit on the ROI end so x0+w never wraps.
  assign rx_end        = {1'b0, rx_q} + {1'b0, rw_q};
  assign ry_end        = {1'b0, ry_q} + {1'b0, rh_q};
  assign in_roi        = rw_q != '0 && rh_q != '0 &&
                         x_q >= rx_q && {1'b0, x_q} < rx_end &&
                         y_q >= ry_q && {1'b0, y_q} < ry_end;
  assign drained       = !m_axis_tvalid || m_axis_tready;
  assign pl_in         = {in_roi, state_q == WAIT_SOF, last_x, s_axis_tdata};
  assign {m_roi, m_axis_tuser, m_axis_tlast, m_axis_tdata} = pl_out;
  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign err           = err_q;
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = start_ok ? 1'b0 : (err_q || err_ev);
    done_d  = state_q == DONE && drained;
    unique case (state_q)
      IDLE: if (start_ok) begin
        state_d = WAIT_SOF;
        x_d     = '0;
        y_d     = '0;
      end
      WAIT_SOF, ACTIVE: if (fwd) begin
        state_d = last_px ? DONE : ACTIVE;
        x_d     = last_x ? '0 : x_q + DIM_W'(1);
        y_d     = last_x ? y_q + DIM_W'(1) : y_q;
      end
      DONE: if (drained) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      {w_q, h_q, rx_q, ry_q, rw_q, rh_q} <= '0;
    end else if (start_ok) begin
      {w_q, h_q, rx_q, ry_q, rw_q, rh_q} <= {cfg_width, cfg_height, roi_x0, roi_y0, roi_w, roi_h};
    end
  end
  face_swap_axis_reg #(.W(DATA_W + 3)) u_out (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .in_data  (pl_in),
    .in_valid (fwd),
    .in_ready (slice_rdy),
    .out_data (pl_out),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready)
  );
`ifdef FACE_SWAP_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) err_cnt_q <= '0;
    else if (err_ev && err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
  end
  assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_face_swap_ctrl.sv
// tb_face_swap_ctrl: randomized frames checked against a coordinate-based frame model.
module tb_face_swap_ctrl;
  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        cfg_start = 1'b0;
  logic [10:0] cfg_width = '0, cfg_height = '0, roi_x0 = '0, roi_y0 = '0, roi_w = '0, roi_h = '0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_roi;
  logic        m_axis_tready = 1'b0;
  logic        busy, done, err;
`ifdef FACE_SWAP_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif
  int total = 0, bad = 0, exp_ec = 0;

  face_swap_ctrl dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cfg_start(cfg_start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_w(roi_w), .roi_h(roi_h),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_roi(m_roi),
    .busy(busy), .done(done), .err(err)
`ifdef FACE_SWAP_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_ec();
`ifdef FACE_SWAP_ERR_CNT_EN
    check("err_cnt", err_cnt, exp_ec);
`endif
  endtask

  // Frame model: pixel i sits at (i%w, i/w); tlast, tuser and ROI follow from coordinates alone.
  task automatic run_frame(input int w, h, rx, ry, rw, rh, junk, early_i, stray_i, rdy_pct, input bit poke);
    logic [33:0] inq[$];
    logic [34:0] expq[$];
    logic [34:0] held = '0;
    logic [31:0] d;
    bit stalled = 0, l, u;
    int n = w * h, mism = 0, cyc = 0, last_cyc = -1, done_cyc = -1, got = 0, x, y;
    int budget = 40 * n + 100;
    for (int j = 0; j < junk; j++) inq.push_back({1'b0, 1'($urandom_range(0, 1)), 32'($urandom)});
    for (int i = 0; i < n; i++) begin
      x = i % w; y = i / w; d = $urandom;
      l = (x == w - 1) || (i == early_i);
      u = (i == 0) || (i == stray_i);
      if (l != (x == w - 1) || (u && i != 0)) mism++;
      inq.push_back({u, l, d});
      expq.push_back({(x >= rx && x < rx + rw && y >= ry && y < ry + rh), i == 0, x == w - 1, d});
    end
    @(negedge ACLK);
    cfg_width = 11'(w); cfg_height = 11'(h);
    roi_x0 = 11'(rx); roi_y0 = 11'(ry); roi_w = 11'(rw); roi_h = 11'(rh);
    cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    check("err_clr", err, 0);
    check("busy_on", busy, 1);
    while ((got < n || done_cyc < 0) && cyc < budget) begin
      m_axis_tready = $urandom_range(0, 99) < rdy_pct;
      s_axis_tvalid = inq.size() > 0 && $urandom_range(0, 3) != 0;
      if (inq.size() > 0) {s_axis_tuser, s_axis_tlast, s_axis_tdata} = inq[0];
      cfg_start = poke && cyc == 3;
      if (poke && cyc == 3) cfg_width = '0;
      #1;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (stalled) check("hold", {m_axis_tvalid, m_roi, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {1'b1, held});
      stalled = m_axis_tvalid && !m_axis_tready;
      held = {m_roi, m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        if (got < n) check("beat", held, expq[got]);
        last_cyc = cyc;
        got++;
      end
      if (s_axis_tvalid && s_axis_tready) void'(inq.pop_front());
      cyc++;
      @(negedge ACLK);
    end
    s_axis_tvalid = 1'b0;
    cfg_start = 1'b0;
    check("frame_done", done_cyc >= 0, 1);
    check("beats", got, n);
    check("in_left", inq.size(), 0);
    check("done_at", done_cyc, last_cyc + 1);
    check("done_pulse", done, 0);
    check("err", err, mism > 0);
    check("busy_off", busy, 0);
    check("rdy_idle", s_axis_tready, 0);
    exp_ec += mism;
    check_ec();
  endtask

  task automatic reset_mid_frame();
    int acc = 0, cyc = 0;
    @(negedge ACLK);
    cfg_width = 11'd4; cfg_height = 11'd2; roi_x0 = '0; roi_y0 = '0; roi_w = 11'd4; roi_h = 11'd2;
    cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    m_axis_tready = 1'b1;
    while (acc < 5 && cyc < 100) begin
      s_axis_tvalid = 1'b1; s_axis_tuser = acc == 0; s_axis_tlast = acc == 3; s_axis_tdata = $urandom;
      #1;
      if (s_axis_tready) acc++;
      cyc++;
      @(negedge ACLK);
    end
    s_axis_tvalid = 1'b0;
    check("rst_feed", acc, 5);
    check("rst_pre_busy", busy, 1);
    #2 ARESETN = 1'b0;
    #1;
    check("rst_outs", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_roi, s_axis_tready, busy, done, err, m_axis_tdata}, 0);
    exp_ec = 0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("rst_idle", {m_axis_tvalid, busy, s_axis_tready}, 0);
    check_ec();
  endtask

  initial begin
    int w, h, n;
    #3;
    check("reset_outs", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_roi, s_axis_tready, busy, done, err, m_axis_tdata}, 0);
    check_ec();
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("idle_rdy", s_axis_tready, 0);
    run_frame(4, 2, 1, 0, 2, 1, 0, -1, -1, 100, 0);
    run_frame(4, 2, 0, 0, 4, 2, 3, -1, -1, 100, 0);
    run_frame(16, 4, 3, 1, 5, 2, 0, -1, -1, 50, 0);
    run_frame(4, 2, 0, 0, 0, 2, 0, 2, -1, 100, 0);
    @(negedge ACLK);
    cfg_width = 11'd4; cfg_height = '0; cfg_start = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tuser = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    #1;
    exp_ec++;
    check("h0_err", err, 1);
    check("h0_busy", busy, 0);
    check("h0_rdy", s_axis_tready, 0);
    check_ec();
    s_axis_tvalid = 1'b0;
    run_frame(6, 3, 1, 1, 2, 1, 0, -1, 10, 70, 1);
    run_frame(5, 2, 1, 0, 2047, 1, 1, -1, -1, 60, 0);
    run_frame(1, 1, 0, 0, 1, 1, 0, -1, -1, 100, 0);
    reset_mid_frame();
    run_frame(4, 2, 1, 0, 2, 1, 0, -1, -1, 100, 0);
    for (int k = 0; k < 6; k++) begin
      w = $urandom_range(1, 8); h = $urandom_range(1, 4); n = w * h;
      run_frame(w, h, $urandom_range(0, w), $urandom_range(0, h), $urandom_range(0, w),
                $urandom_range(0, h), $urandom_range(0, 2), -1, -1, $urandom_range(30, 100), n >= 8);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
